ucore_fire_ctrl: RTL

- Firing controller for one RipTide ucore.
- Watches the valid flags of the ucore input channels. When every configured operand is present, it pulses per-channel consume strobes and starts the functional unit (FU).
- Counts out a configured FU latency, then captures the FU result in an output register and offers it to the NoC with a valid/ready handshake.
- Sits between the ucore input channel buffers, the FU and the ucore output port. It also accepts per-ucore configuration: operand mask and latency.

---
 rtl/ucore_fire_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ucore_fire_ctrl.sv
// Firing controller for one RipTide ucore. It waits for all configured operands,
// launches the FU, counts out its latency, and offers the result over valid/ready.
module ucore_fire_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 2,
    parameter int LAT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    input  logic [NUM_INPUTS-1:0] cfg_in_mask,
    input  logic [LAT_WIDTH-1:0]  cfg_latency,
    output logic                  cfg_ready,
    input  logic [NUM_INPUTS-1:0] in_valid,
    output logic [NUM_INPUTS-1:0] in_consume,
    output logic                  fu_start,
    input  logic [DATA_WIDTH-1:0] fu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        IDLE  = 2'd1,
        EXEC  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_INPUTS-1:0]   mask_q, mask_d;
    logic [LAT_WIDTH-1:0]    lat_q, lat_d;
    logic [LAT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    fire_cond;
    logic                    do_fire;

    assign fire_cond = (mask_q != '0) && ((in_valid & mask_q) == mask_q);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        lat_d      = lat_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        do_fire    = 1'b0;
        cfg_ready  = 1'b0;
        out_valid  = 1'b0;
        in_consume = '0;
        fu_start   = 1'b0;

        case (state_q)
            UNCFG: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    mask_d  = cfg_in_mask;
                    lat_d   = cfg_latency;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cfg_ready = 1'b1;
                // A configuration write wins over a simultaneous firing opportunity.
                if (cfg_valid) begin
                    mask_d = cfg_in_mask;
                    lat_d  = cfg_latency;
                end else if (fire_cond) begin
                    do_fire = 1'b1;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - LAT_WIDTH'(1);
                if (cnt_q <= LAT_WIDTH'(1)) begin
                    data_d  = fu_result;
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (fire_cond) begin
                        do_fire = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = UNCFG;
        endcase

        if (do_fire) begin
            if (lat_q == '0) begin
                data_d  = fu_result;
                state_d = OUT;
            end else begin
                cnt_d   = lat_q;
                state_d = EXEC;
            end
            // Strobes are suppressed while reset is asserted so no operand is lost.
            if (!reset) begin
                in_consume = mask_q;
                fu_start   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNCFG;
            mask_q  <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign out_data = data_q;
    assign busy     = (state_q == EXEC) || (state_q == OUT);

endmodule
